// File: rtl/npu_col_feeder.sv
// Streams raster pixels into K_H-1 line buffers and drives the NPU host port with
// column loads plus clear/trigger/next-state control writes for a full conv pass.
module npu_col_feeder #(
  parameter int K_H      = 3,
  parameter int K_W      = 3,
  parameter int IN_H     = 16,
  parameter int IN_W     = 15,
  parameter int TRIG_GAP = 3
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        npu_ena,
  output logic        npu_wea,
  output logic [15:0] npu_addra,
  output logic [31:0] npu_dina,
  output logic        busy,
  output logic        done
);

  localparam int NB = K_H - 1;
  localparam int SW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int GW = (TRIG_GAP > 1) ? $clog2(TRIG_GAP) : 1;

  localparam logic [15:0] ADDR_COL  = 16'h1000;
  localparam logic [15:0] ADDR_CTRL = 16'h4000;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_CLR, S_COL, S_TRIG, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t          state, state_next;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [SW-1:0]   base;
  logic [GW-1:0]   gap, gap_next;
  logic [7:0]      pix_q;
  logic            armed;

  logic            xfer;
  logic            adv;
  logic            go;
  logic            lb_we;
  logic [7:0]      lb_wdata;
  logic            wr_en;
  logic [15:0]     wr_addr;
  logic [31:0]     wr_data;
  logic [31:0]     col_word;
  logic [8*NB-1:0] rd_flat;
  logic            last_col, last_row, fill_row;
  int              slot;

  assign pix_ready = (state == S_ACCEPT);
  assign xfer      = pix_valid & pix_ready;
  assign go        = (state == S_IDLE) & start & armed;
  assign last_col  = (col == CW'(IN_W - 1));
  assign last_row  = (row == RW'(IN_H - 1));
  assign fill_row  = (row < RW'(K_H - 1));
  assign lb_wdata  = (state == S_COL) ? pix_q : pix_data;

  // One RAM per buffered row; base names the slot holding the oldest row.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lb
      logic [7:0] mem [IN_W];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
        if (lb_we && (base == SW'(gi)))
          mem[col] <= lb_wdata;
        if (xfer)
          rd_q <= mem[col];
      end
      assign rd_flat[8*gi +: 8] = rd_q;
    end
  endgenerate

  // Byte i carries row r-K_H+1+i, found NB-rotated from the oldest slot.
  always_comb begin
    col_word = '0;
    slot     = 0;
    for (int i = 0; i < NB; i++) begin
      slot = int'(base) + i;
      if (slot >= NB)
        slot = slot - NB;
      col_word[8*i +: 8] = rd_flat[8*slot +: 8];
    end
    col_word[8*NB +: 8] = pix_q;
  end

  always_comb begin
    state_next = state;
    gap_next   = gap;
    adv        = 1'b0;
    lb_we      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    case (state)
      S_IDLE: begin
        if (go)
          state_next = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (xfer) begin
          if (fill_row) begin
            lb_we = 1'b1;
            adv   = 1'b1;
          end else begin
            state_next = (col == '0) ? S_CLR : S_COL;
          end
        end
      end
      S_CLR: begin
        wr_en      = 1'b1;
        wr_addr    = ADDR_CTRL;
        wr_data    = 32'h8;
        state_next = S_COL;
      end
      S_COL: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_COL;
        wr_data = col_word;
        lb_we   = 1'b1;
        if (col >= CW'(K_W - 1)) begin
          state_next = S_TRIG;
        end else begin
          adv        = 1'b1;
          state_next = S_ACCEPT;
        end
      end
      S_TRIG: begin
        wr_en      = 1'b1;
        wr_addr    = ADDR_CTRL;
        wr_data    = 32'h1;
        gap_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (gap == GW'(TRIG_GAP - 1)) begin
          if (last_row && last_col) begin
            state_next = S_NEXT;
          end else begin
            adv        = 1'b1;
            state_next = S_ACCEPT;
          end
        end else begin
          gap_next = gap + 1'b1;
        end
      end
      S_NEXT: begin
        wr_en      = 1'b1;
        wr_addr    = ADDR_CTRL;
        wr_data    = 32'h2;
        state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // armed blocks a start that coincides with the first edge after reset release.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      row   <= '0;
      col   <= '0;
      base  <= '0;
      gap   <= '0;
      pix_q <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      gap   <= gap_next;
      armed <= 1'b1;
      if (xfer)
        pix_q <= pix_data;
      if (go) begin
        row  <= '0;
        col  <= '0;
        base <= '0;
      end else if (adv) begin
        if (last_col) begin
          col  <= '0;
          row  <= row + 1'b1;
          base <= (base == SW'(NB - 1)) ? '0 : base + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      npu_ena   <= 1'b0;
      npu_wea   <= 1'b0;
      npu_addra <= '0;
      npu_dina  <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      npu_ena   <= wr_en;
      npu_wea   <= wr_en;
      npu_addra <= wr_en ? wr_addr : '0;
      npu_dina  <= wr_en ? wr_data : '0;
      done      <= (state == S_DONE);
      busy      <= (state_next != S_IDLE) || (state == S_DONE);
    end
  end

endmodule
